alu: RTL and testbench
======================

ALU -- requirements
Module: alu

Interface
REQ-001 SHALL: clk  input  1  -- single clock; all state updates on its rising edge.
REQ-002 SHALL: rstn  input  1  -- asynchronous, active-low reset.
REQ-003 SHALL: ain  input  32  -- operand A.
REQ-004 SHALL: bin  input  32  -- operand B.
REQ-005 SHALL: ALUop  input  5  -- operation select; encoding per REQ-008.
REQ-006 SHALL: ALUout  output  32  -- registered result.

Function
REQ-007 SHALL: result computed combinationally from ain, bin, ALUop and loaded into ALUout on every rising clk; latency exactly 1 cycle, no handshake, no stall.
REQ-008 SHALL: ALUop encoding:
- 0 ADD
- 1 SUB (ain-bin)
- 2 MUL (low 32 of product)
- 3 MULH (signed x signed, high 32)
- 4 MULHSU (signed ain x unsigned bin, high 32)
- 5 MULHU (unsigned x unsigned, high 32)
- 6 DIV (signed)
- 7 DIVU
- 8 REM (signed)
- 9 REMU
- 10 AND
- 11 OR
- 12 XOR
- 13 SLL
- 14 SRL
- 15 SRA
- 16 SLT
- 17 SLTU
REQ-009 SHALL: ADD/SUB wrap modulo 2^32; no carry or overflow flags.
REQ-010 SHALL: multiplies form the full 64-bit product with operand extension per signedness (sign-extend signed operands, zero-extend unsigned).
REQ-011 SHALL: signed DIV truncates toward zero; signed REM takes the sign of the dividend.
REQ-012 SHALL: divide by zero (bin=0) -> DIV/DIVU = 0xFFFFFFFF, REM/REMU = ain.
REQ-013 SHALL: signed overflow (ain=0x80000000, bin=0xFFFFFFFF) -> DIV = 0x80000000, REM = 0.
REQ-014 SHALL: shifts use bin[4:0] as amount; SRA replicates ain[31].
REQ-015 SHALL: SLT/SLTU return 32'd1 if ain<bin (signed/unsigned compare), else 0.
REQ-016 SHALL: ALUop 18..31 reserved -> ALUout loads 0.
REQ-017 SHALL: operand or ALUop change takes effect on the next rising edge only; ALUout holds between edges.

Reset
REQ-018 SHALL: rstn low clears ALUout to 0 immediately, independent of clk, and holds it at 0 while low.
REQ-019 SHALL: first rising edge after rstn deasserts loads the result for the current inputs.
REQ-020 SHALL: rstn asserted mid-sequence discards the in-flight result; no state other than ALUout exists.

Verification
REQ-021 SHALL: reset, then ain=0xABCD4C63, bin=0x0F3B6622, ALUop stepped 0..9 one per cycle -> ALUop 0 gives 0xBB08B285 and ALUop 1 gives 0x9C91E641, each one cycle after its op is applied; every other result is checked against a golden model.
REQ-022 SHALL: ain=0xFFFFFFFF, bin=2 -> MUL 0xFFFFFFFE, MULH 0xFFFFFFFF, MULHSU 0xFFFFFFFF, MULHU 0x00000001.
REQ-023 SHALL: ain=0xFFFFFFF9 (-7), bin=2 -> DIV 0xFFFFFFFD, REM 0xFFFFFFFF, DIVU 0x7FFFFFFC, REMU 0x00000001.
REQ-024 SHALL: bin=0, ain=0x12345678 -> DIV/DIVU 0xFFFFFFFF, REM/REMU 0x12345678; and ain=0x80000000, bin=0xFFFFFFFF -> DIV 0x80000000, REM 0.
REQ-025 SHALL: ALUout nonzero, rstn pulsed low between clock edges -> ALUout 0 before next edge; ALUop=20 after release -> ALUout stays 0.

Source files
------------

// File: rtl/alu.sv
// ---------------------------------------------------------------------------
// alu: 32-bit integer ALU with a single registered result.
// The result is formed combinationally from ain/bin/ALUop and captured into
// ALUout on every rising clk edge (1-cycle latency, no handshake).
// ---------------------------------------------------------------------------
module alu (
   input  logic        clk,
   input  logic        rstn,
   input  logic [31:0] ain,
   input  logic [31:0] bin,
   input  logic [4:0]  ALUop,
   output logic [31:0] ALUout
);

   typedef enum logic [4:0] {
      OP_ADD    = 5'd0,  OP_SUB    = 5'd1,  OP_MUL  = 5'd2,  OP_MULH = 5'd3,
      OP_MULHSU = 5'd4,  OP_MULHU  = 5'd5,  OP_DIV  = 5'd6,  OP_DIVU = 5'd7,
      OP_REM    = 5'd8,  OP_REMU   = 5'd9,  OP_AND  = 5'd10, OP_OR   = 5'd11,
      OP_XOR    = 5'd12, OP_SLL    = 5'd13, OP_SRL  = 5'd14, OP_SRA  = 5'd15,
      OP_SLT    = 5'd16, OP_SLTU   = 5'd17
   } alu_op_e;

   logic [31:0] alu_out_q, alu_out_d;

   // One shared 64x64 multiplier; operand extension follows the op's signedness.
   logic        a_sgn, b_sgn;
   logic [63:0] a_ext, b_ext, prod;

   // Division works on magnitudes so the signed overflow case needs no special
   // hardware: |0x80000000| / 1 = 0x80000000, negated back to 0x80000000, rem 0.
   logic        b_zero;
   logic [31:0] a_mag, b_mag, div_b, uq_s, ur_s, uq_u, ur_u, q_s, r_s;

   logic [4:0]  shamt;

   // Operand extension, product and divider datapath.
   always_comb begin
      a_sgn  = (ALUop == OP_MULH) || (ALUop == OP_MULHSU);
      b_sgn  = (ALUop == OP_MULH);
      a_ext  = {{32{a_sgn & ain[31]}}, ain};
      b_ext  = {{32{b_sgn & bin[31]}}, bin};
      prod   = a_ext * b_ext;

      b_zero = (bin == 32'd0);
      a_mag  = ain[31] ? (32'd0 - ain) : ain;
      b_mag  = bin[31] ? (32'd0 - bin) : bin;
      // A nonzero divisor is substituted on /0; the result is overridden below.
      div_b  = b_zero ? 32'd1 : b_mag;
      uq_s   = a_mag / div_b;
      ur_s   = a_mag % div_b;
      uq_u   = ain / (b_zero ? 32'd1 : bin);
      ur_u   = ain % (b_zero ? 32'd1 : bin);
      q_s    = (ain[31] ^ bin[31]) ? (32'd0 - uq_s) : uq_s;
      r_s    = ain[31] ? (32'd0 - ur_s) : ur_s;
      shamt  = bin[4:0];
   end

   // Result select; reserved opcodes produce 0.
   always_comb begin
      alu_out_d = 32'd0;
      case (ALUop)
         OP_ADD:    alu_out_d = ain + bin;
         OP_SUB:    alu_out_d = ain - bin;
         OP_MUL:    alu_out_d = prod[31:0];
         OP_MULH,
         OP_MULHSU,
         OP_MULHU:  alu_out_d = prod[63:32];
         OP_DIV:    alu_out_d = b_zero ? 32'hFFFF_FFFF : q_s;
         OP_DIVU:   alu_out_d = b_zero ? 32'hFFFF_FFFF : uq_u;
         OP_REM:    alu_out_d = b_zero ? ain : r_s;
         OP_REMU:   alu_out_d = b_zero ? ain : ur_u;
         OP_AND:    alu_out_d = ain & bin;
         OP_OR:     alu_out_d = ain | bin;
         OP_XOR:    alu_out_d = ain ^ bin;
         OP_SLL:    alu_out_d = ain << shamt;
         OP_SRL:    alu_out_d = ain >> shamt;
         OP_SRA:    alu_out_d = $unsigned($signed(ain) >>> shamt);
         OP_SLT:    alu_out_d = {31'd0, ($signed(ain) < $signed(bin))};
         OP_SLTU:   alu_out_d = {31'd0, (ain < bin)};
         default:   alu_out_d = 32'd0;
      endcase
   end

   // Result register; async reset clears it immediately.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) alu_out_q <= 32'd0;
      else       alu_out_q <= alu_out_d;
   end

   assign ALUout = alu_out_q;

endmodule

// File: tb/tb_alu.sv
// ---------------------------------------------------------------------------
// tb_alu: directed self-checking bench for alu.
// ---------------------------------------------------------------------------
module tb_alu;

   logic        clk;
   logic        rstn;
   logic [31:0] ain, bin;
   logic [4:0]  ALUop;
   logic [31:0] ALUout;

   int checks   = 0;
   int failures = 0;

   alu dut (
      .clk    (clk),
      .rstn   (rstn),
      .ain    (ain),
      .bin    (bin),
      .ALUop  (ALUop),
      .ALUout (ALUout)
   );

   // 10-unit clock.
   always #5 clk = ~clk;

   // Reference built from native SV 64-bit / signed arithmetic.
   function automatic logic [31:0] gold(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
      longint      sa, sb, ub;
      logic [63:0] p;
      int          ia, ib;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      ub = longint'({32'd0, b});
      ia = $signed(a);
      ib = $signed(b);
      gold = 32'd0;
      case (op)
         5'd0: gold = a + b;
         5'd1: gold = a - b;
         5'd2: begin p = 64'(sa * sb); gold = p[31:0]; end
         5'd3: begin p = 64'(sa * sb); gold = p[63:32]; end
         5'd4: begin p = 64'(sa * ub); gold = p[63:32]; end
         5'd5: begin p = {32'd0, a} * {32'd0, b}; gold = p[63:32]; end
         5'd6: gold = 32'(ia / ib);
         5'd7: gold = a / b;
         5'd8: gold = 32'(ia % ib);
         5'd9: gold = a % b;
         default: gold = 32'd0;
      endcase
   endfunction

   task automatic test_reset();
      ain = 32'd1; bin = 32'd2; ALUop = 5'd0;
      #2;
      checks++;
      if (ALUout !== 32'd0) begin failures++; $display("FAIL reset_async got=%h exp=%h", ALUout, 32'd0); end
      repeat (2) @(posedge clk);
      #1;
      checks++;
      if (ALUout !== 32'd0) begin failures++; $display("FAIL reset_hold got=%h exp=%h", ALUout, 32'd0); end
      @(negedge clk);
      rstn = 1'b1;
      #1;
      checks++;
      if (ALUout !== 32'd0) begin failures++; $display("FAIL reset_release got=%h exp=%h", ALUout, 32'd0); end
      @(posedge clk);
      #1;
      checks++;
      if (ALUout !== 32'd3) begin failures++; $display("FAIL reset_first_edge got=%h exp=%h", ALUout, 32'd3); end
   endtask

   // ALUop 0..9 one per cycle; also checks the output holds until the next edge.
   task automatic test_sequence();
      logic [31:0] exp, prev;
      ain = 32'hABCD_4C63; bin = 32'h0F3B_6622;
      prev = ALUout;
      for (int op = 0; op < 10; op++) begin
         ALUop = 5'(op);
         #2;
         checks++;
         if (ALUout !== prev) begin failures++; $display("FAIL seq_hold op=%0d got=%h exp=%h", op, ALUout, prev); end
         if (op == 0)      exp = 32'hBB08_B285;
         else if (op == 1) exp = 32'h9C91_E641;
         else              exp = gold(5'(op), ain, bin);
         @(posedge clk);
         #1;
         checks++;
         if (ALUout !== exp) begin failures++; $display("FAIL seq op=%0d got=%h exp=%h", op, ALUout, exp); end
         prev = exp;
      end
   endtask

   task automatic test_mul();
      logic [4:0]  ops [4] = '{5'd2, 5'd3, 5'd4, 5'd5};
      logic [31:0] exps[4] = '{32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001};
      ain = 32'hFFFF_FFFF; bin = 32'd2;
      for (int i = 0; i < 4; i++) begin
         ALUop = ops[i];
         @(posedge clk);
         #1;
         checks++;
         if (ALUout !== exps[i]) begin failures++; $display("FAIL mul op=%0d got=%h exp=%h", ops[i], ALUout, exps[i]); end
      end
   endtask

   task automatic test_div();
      logic [4:0]  ops [4] = '{5'd6, 5'd8, 5'd7, 5'd9};
      logic [31:0] exps[4] = '{32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'h7FFF_FFFC, 32'h0000_0001};
      ain = 32'hFFFF_FFF9; bin = 32'd2;
      for (int i = 0; i < 4; i++) begin
         ALUop = ops[i];
         @(posedge clk);
         #1;
         checks++;
         if (ALUout !== exps[i]) begin failures++; $display("FAIL div op=%0d got=%h exp=%h", ops[i], ALUout, exps[i]); end
      end
   endtask

   task automatic test_div_corner();
      logic [4:0]  ops [6] = '{5'd6, 5'd7, 5'd8, 5'd9, 5'd6, 5'd8};
      logic [31:0] as  [6] = '{32'h1234_5678, 32'h1234_5678, 32'h1234_5678, 32'h1234_5678,
                               32'h8000_0000, 32'h8000_0000};
      logic [31:0] bs  [6] = '{32'd0, 32'd0, 32'd0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
      logic [31:0] exps[6] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h1234_5678, 32'h1234_5678,
                               32'h8000_0000, 32'h0000_0000};
      for (int i = 0; i < 6; i++) begin
         ALUop = ops[i]; ain = as[i]; bin = bs[i];
         @(posedge clk);
         #1;
         checks++;
         if (ALUout !== exps[i]) begin failures++; $display("FAIL div_corner i=%0d op=%0d got=%h exp=%h", i, ops[i], ALUout, exps[i]); end
      end
   endtask

   task automatic test_logic_shift();
      logic [4:0]  ops [10] = '{5'd10, 5'd11, 5'd12, 5'd13, 5'd14, 5'd15, 5'd16, 5'd17, 5'd14, 5'd15};
      logic [31:0] bs  [10] = '{32'h24, 32'h24, 32'h24, 32'h24, 32'h24, 32'h24, 32'h24, 32'h24,
                                32'h3F, 32'h3F};
      logic [31:0] exps[10] = '{32'h0000_0000, 32'h8000_0034, 32'h8000_0034, 32'h0000_0100,
                                32'h0800_0001, 32'hF800_0001, 32'h0000_0001, 32'h0000_0000,
                                32'h0000_0001, 32'hFFFF_FFFF};
      ain = 32'h8000_0010;
      for (int i = 0; i < 10; i++) begin
         ALUop = ops[i]; bin = bs[i];
         @(posedge clk);
         #1;
         checks++;
         if (ALUout !== exps[i]) begin failures++; $display("FAIL logic_shift op=%0d got=%h exp=%h", ops[i], ALUout, exps[i]); end
      end
   endtask

   task automatic test_reserved();
      logic [4:0] ops[3] = '{5'd18, 5'd25, 5'd31};
      ain = 32'hDEAD_BEEF; bin = 32'h1234_5678;
      for (int i = 0; i < 3; i++) begin
         ALUop = 5'd11;
         @(posedge clk);
         ALUop = ops[i];
         @(posedge clk);
         #1;
         checks++;
         if (ALUout !== 32'd0) begin failures++; $display("FAIL reserved op=%0d got=%h exp=%h", ops[i], ALUout, 32'd0); end
      end
   endtask

   task automatic test_reset_midseq();
      ain = 32'd5; bin = 32'd6; ALUop = 5'd0;
      @(posedge clk);
      #1;
      checks++;
      if (ALUout !== 32'd11) begin failures++; $display("FAIL midrst_pre got=%h exp=%h", ALUout, 32'd11); end
      ALUop = 5'd2;
      #2 rstn = 1'b0;
      #1;
      checks++;
      if (ALUout !== 32'd0) begin failures++; $display("FAIL midrst_async got=%h exp=%h", ALUout, 32'd0); end
      #1 rstn = 1'b1;
      ALUop = 5'd20;
      for (int i = 0; i < 2; i++) begin
         @(posedge clk);
         #1;
         checks++;
         if (ALUout !== 32'd0) begin failures++; $display("FAIL midrst_reserved cyc=%0d got=%h exp=%h", i, ALUout, 32'd0); end
      end
      ALUop = 5'd2;
      @(posedge clk);
      #1;
      checks++;
      if (ALUout !== 32'd30) begin failures++; $display("FAIL midrst_resume got=%h exp=%h", ALUout, 32'd30); end
   endtask

   initial begin
      clk = 1'b0; rstn = 1'b1; ain = '0; bin = '0; ALUop = '0;
      #1 rstn = 1'b0;
      test_reset();
      test_sequence();
      test_mul();
      test_div();
      test_div_corner();
      test_logic_shift();
      test_reserved();
      test_reset_midseq();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
